// File: rtl/pc_stack_unit_pkg.sv
// Shared constants for the PIC10-compatible PC / call-stack block.
package pc_stack_unit_pkg;

    localparam int PC_WIDTH_DEF    = 9;
    localparam int STACK_DEPTH_DEF = 2;

    // PC load source encodings (value 3 aliases the ALU path)
    localparam logic [1:0] PC_MUX_STACK   = 2'd0;
    localparam logic [1:0] PC_MUX_ALU     = 2'd1;
    localparam logic [1:0] PC_MUX_IR      = 2'd2;
    localparam logic [1:0] PC_MUX_ALU_ALT = 2'd3;

    // Width of a pointer into a stack of the given depth (at least one bit)
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pc_stack_unit_call_stack.sv
// Circular return stack: entries, pointer, occupancy count and sticky
// overflow/underflow flags. A push at full overwrites the oldest entry.
module pc_stack_unit_call_stack
    import pc_stack_unit_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_stack,
    input  logic                inc_stack,
    input  logic                dec_stack,
    input  logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] stack_top,
    output logic                stack_overflow,
    output logic                stack_underflow
);

    localparam int SP_W  = ptr_width(STACK_DEPTH);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam logic [SP_W-1:0]  SP_LAST    = SP_W'(STACK_DEPTH - 1);
    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(STACK_DEPTH);

    logic [PC_WIDTH-1:0] entries [STACK_DEPTH];
    logic [SP_W-1:0]     sp;
    logic [SP_W-1:0]     sp_up;
    logic [SP_W-1:0]     sp_dn;
    logic [SP_W-1:0]     sp_next;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_next;
    logic                overflow_next;
    logic                underflow_next;

    assign sp_up     = (sp == SP_LAST) ? {SP_W{1'b0}} : sp + SP_W'(1);
    assign sp_dn     = (sp == {SP_W{1'b0}}) ? SP_LAST : sp - SP_W'(1);
    assign stack_top = entries[sp];

    // Pointer/count/flag next state; simultaneous push and pop cancel out
    always_comb begin
        sp_next        = sp;
        count_next     = count;
        overflow_next  = stack_overflow;
        underflow_next = stack_underflow;
        if (inc_stack && !dec_stack) begin
            sp_next = sp_up;
            if (count == COUNT_FULL) begin
                overflow_next = 1'b1;
            end else begin
                count_next = count + CNT_W'(1);
            end
        end else if (dec_stack && !inc_stack) begin
            sp_next = sp_dn;
            if (count == {CNT_W{1'b0}}) begin
                underflow_next = 1'b1;
            end else begin
                count_next = count - CNT_W'(1);
            end
        end else begin
            sp_next = sp;
        end
    end

    // Stack storage and control registers; the write uses the pre-edge pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                entries[i] <= {PC_WIDTH{1'b0}};
            end
            sp              <= {SP_W{1'b0}};
            count           <= {CNT_W{1'b0}};
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            if (load_stack) begin
                entries[sp] <= pc;
            end
            sp              <= sp_next;
            count           <= count_next;
            stack_overflow  <= overflow_next;
            stack_underflow <= underflow_next;
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter, PC source mux and skip-squash flag for the PIC10 core,
// with the return stack in a sub-module. All state updates on posedge.
module pc_stack_unit
    import pc_stack_unit_pkg::*;
#(
    parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
    parameter int                  STACK_DEPTH  = STACK_DEPTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          pc_mux_select,
    input  logic                load_pc,
    input  logic                inc_pc,
    input  logic                skip_next_instruction,
    input  logic                load_stack,
    input  logic                inc_stack,
    input  logic                dec_stack,
    input  logic [7:0]          alu_out,
    input  logic [11:0]         instruction_reg_out,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [PC_WIDTH-1:0] stack_top,
    output logic                squash_ir,
    output logic                stack_overflow,
    output logic                stack_underflow
);

    logic [PC_WIDTH-1:0] pc_source;

    // PC load source; ALU loads clear every bit above bit 7
    always_comb begin
        case (pc_mux_select)
            PC_MUX_STACK:   pc_source = stack_top;
            PC_MUX_ALU:     pc_source = PC_WIDTH'(alu_out);
            PC_MUX_IR:      pc_source = PC_WIDTH'(instruction_reg_out[8:0]);
            PC_MUX_ALU_ALT: pc_source = PC_WIDTH'(alu_out);
            default:        pc_source = PC_WIDTH'(alu_out);
        endcase
    end

    // PC register: load beats increment, increment wraps modulo 2^PC_WIDTH
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out <= RESET_VECTOR;
        end else if (load_pc) begin
            pc_out <= pc_source;
        end else if (inc_pc) begin
            pc_out <= pc_out + PC_WIDTH'(1);
        end else begin
            pc_out <= pc_out;
        end
    end

    // Squash flag follows the skip request only on fetch-advancing edges
    always_ff @(posedge clk) begin
        if (rst) begin
            squash_ir <= 1'b0;
        end else if (inc_pc) begin
            squash_ir <= skip_next_instruction;
        end else begin
            squash_ir <= squash_ir;
        end
    end

    pc_stack_unit_call_stack #(
        .PC_WIDTH    (PC_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_call_stack (
        .clk             (clk),
        .rst             (rst),
        .load_stack      (load_stack),
        .inc_stack       (inc_stack),
        .dec_stack       (dec_stack),
        .pc              (pc_out),
        .stack_top       (stack_top),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed scenarios plus a
// randomized run checked against a behavioural model of PC and stack.
module tb_pc_stack_unit;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pc_mux_select = 2'd0;
    logic        load_pc = 1'b0;
    logic        inc_pc = 1'b0;
    logic        skip_next_instruction = 1'b0;
    logic        load_stack = 1'b0;
    logic        inc_stack = 1'b0;
    logic        dec_stack = 1'b0;
    logic [7:0]  alu_out = 8'd0;
    logic [11:0] instruction_reg_out = 12'd0;
    logic [8:0]  pc_out;
    logic [8:0]  stack_top;
    logic        squash_ir;
    logic        stack_overflow;
    logic        stack_underflow;

    int vectors = 0;
    int miscompares = 0;

    // behavioural model state
    int m_pc, m_sp, m_cnt;
    int m_stk [D];
    bit m_sq, m_ovf, m_unf;

    pc_stack_unit dut (
        .clk                   (clk),
        .rst                   (rst),
        .pc_mux_select         (pc_mux_select),
        .load_pc               (load_pc),
        .inc_pc                (inc_pc),
        .skip_next_instruction (skip_next_instruction),
        .load_stack            (load_stack),
        .inc_stack             (inc_stack),
        .dec_stack             (dec_stack),
        .alu_out               (alu_out),
        .instruction_reg_out   (instruction_reg_out),
        .pc_out                (pc_out),
        .stack_top             (stack_top),
        .squash_ir             (squash_ir),
        .stack_overflow        (stack_overflow),
        .stack_underflow       (stack_underflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle of strobes, advance the model across the edge, settle.
    task automatic cycle(input bit r, input bit lp, input bit [1:0] sel, input bit ip,
                         input bit sk, input bit ls, input bit is, input bit ds,
                         input bit [7:0] alu, input bit [11:0] ir);
        int new_pc;
        rst = r; load_pc = lp; pc_mux_select = sel; inc_pc = ip;
        skip_next_instruction = sk; load_stack = ls; inc_stack = is; dec_stack = ds;
        alu_out = alu; instruction_reg_out = ir;
        @(posedge clk);
        if (r) begin
            m_pc = 0; m_sp = 0; m_cnt = 0; m_sq = 0; m_ovf = 0; m_unf = 0;
            for (int i = 0; i < D; i++) m_stk[i] = 0;
        end else begin
            new_pc = m_pc;
            if (lp) begin
                if (sel == 2'd0)      new_pc = m_stk[m_sp];
                else if (sel == 2'd2) new_pc = ir % 512;
                else                  new_pc = alu;
            end else if (ip) begin
                new_pc = (m_pc + 1) % 512;
            end
            if (ls) m_stk[m_sp] = m_pc;
            if (is && !ds) begin
                if (m_cnt == D) m_ovf = 1; else m_cnt++;
                m_sp = (m_sp + 1) % D;
            end
            if (ds && !is) begin
                if (m_cnt == 0) m_unf = 1; else m_cnt--;
                m_sp = (m_sp + D - 1) % D;
            end
            if (ip) m_sq = sk;
            m_pc = new_pc;
        end
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 2'd0, 0, 0, 0, 0, 0, 8'd0, 12'd0);
    endtask

    task automatic do_reset();
        cycle(1, 0, 2'd0, 0, 0, 0, 0, 0, 8'd0, 12'd0);
    endtask

    task automatic do_goto(input bit [11:0] ir);
        cycle(0, 1, 2'd2, 0, 0, 0, 0, 0, 8'd0, ir);
    endtask

    task automatic do_call(input bit [7:0] target);
        cycle(0, 1, 2'd1, 0, 0, 1, 0, 0, target, 12'd0);
        cycle(0, 0, 2'd0, 0, 0, 0, 1, 0, 8'd0, 12'd0);
    endtask

    task automatic do_retlw();
        cycle(0, 0, 2'd0, 0, 0, 0, 0, 1, 8'd0, 12'd0);
        cycle(0, 1, 2'd0, 0, 0, 0, 0, 0, 8'd0, 12'd0);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (pc_out !== 9'h000) begin miscompares++; $display("FAIL reset_pc got %h want 000", pc_out); end
        vectors++; if (stack_top !== 9'h000) begin miscompares++; $display("FAIL reset_top got %h want 000", stack_top); end
        vectors++; if ({squash_ir, stack_overflow, stack_underflow} !== 3'b000) begin
            miscompares++; $display("FAIL reset_flags got %b want 000", {squash_ir, stack_overflow, stack_underflow}); end
        for (int i = 1; i <= 3; i++) begin
            cycle(0, 0, 2'd0, 1, 0, 0, 0, 0, 8'd0, 12'd0);
            vectors++; if (pc_out !== 9'(i)) begin miscompares++; $display("FAIL inc_pc got %h want %h", pc_out, 9'(i)); end
            vectors++; if (squash_ir !== 1'b0) begin miscompares++; $display("FAIL inc_squash got %b want 0", squash_ir); end
        end
    endtask

    task automatic test_call_ret();
        do_reset();
        do_goto(12'h005);
        do_call(8'h40);
        vectors++; if (pc_out !== 9'h040) begin miscompares++; $display("FAIL call_pc got %h want 040", pc_out); end
        cycle(0, 0, 2'd0, 0, 0, 0, 0, 1, 8'd0, 12'd0);
        vectors++; if (stack_top !== 9'h005) begin miscompares++; $display("FAIL call_ret_addr got %h want 005", stack_top); end
        cycle(0, 1, 2'd0, 0, 0, 0, 0, 0, 8'd0, 12'd0);
        vectors++; if (pc_out !== 9'h005) begin miscompares++; $display("FAIL retlw_pc got %h want 005", pc_out); end
        vectors++; if ({stack_overflow, stack_underflow} !== 2'b00) begin
            miscompares++; $display("FAIL call_flags got %b want 00", {stack_overflow, stack_underflow}); end
    endtask

    task automatic test_overflow();
        do_reset();
        do_goto(12'h010);
        do_call(8'h20);
        do_call(8'h30);
        vectors++; if (stack_overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early got %b want 0", stack_overflow); end
        do_call(8'h44);
        vectors++; if (stack_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set got %b want 1", stack_overflow); end
        vectors++; if (pc_out !== 9'h044) begin miscompares++; $display("FAIL ovf_pc got %h want 044", pc_out); end
        do_retlw();
        vectors++; if (pc_out !== 9'h030) begin miscompares++; $display("FAIL ovf_ret1 got %h want 030", pc_out); end
        do_retlw();
        vectors++; if (pc_out !== 9'h020) begin miscompares++; $display("FAIL ovf_ret2 got %h want 020", pc_out); end
        vectors++; if (stack_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b want 1", stack_overflow); end
    endtask

    task automatic test_underflow();
        do_reset();
        cycle(0, 0, 2'd0, 0, 0, 0, 0, 1, 8'd0, 12'd0);
        vectors++; if (stack_underflow !== 1'b1) begin miscompares++; $display("FAIL unf_set got %b want 1", stack_underflow); end
        // count stayed 0, so a fresh push/pop pair must not flag again nor clear it
        do_goto(12'h0AA);
        cycle(0, 0, 2'd0, 0, 0, 1, 1, 0, 8'd0, 12'd0);
        cycle(0, 0, 2'd0, 0, 0, 0, 0, 1, 8'd0, 12'd0);
        vectors++; if (stack_top !== 9'h0AA) begin miscompares++; $display("FAIL unf_pushpop got %h want 0AA", stack_top); end
        vectors++; if (stack_underflow !== 1'b1) begin miscompares++; $display("FAIL unf_sticky got %b want 1", stack_underflow); end
        do_reset();
        vectors++; if (stack_underflow !== 1'b0) begin miscompares++; $display("FAIL unf_clear got %b want 0", stack_underflow); end
    endtask

    task automatic test_goto_wrap();
        do_reset();
        do_goto(12'hBFF);
        vectors++; if (pc_out !== 9'h1FF) begin miscompares++; $display("FAIL goto_pc got %h want 1FF", pc_out); end
        cycle(0, 0, 2'd0, 1, 1, 0, 0, 0, 8'd0, 12'd0);
        vectors++; if (pc_out !== 9'h000) begin miscompares++; $display("FAIL wrap_pc got %h want 000", pc_out); end
        vectors++; if (squash_ir !== 1'b1) begin miscompares++; $display("FAIL skip_squash got %b want 1", squash_ir); end
        cycle(0, 0, 2'd0, 0, 1, 0, 0, 0, 8'd0, 12'd0);
        vectors++; if (squash_ir !== 1'b1) begin miscompares++; $display("FAIL squash_hold got %b want 1", squash_ir); end
        cycle(0, 0, 2'd0, 1, 0, 0, 0, 0, 8'd0, 12'd0);
        vectors++; if (squash_ir !== 1'b0) begin miscompares++; $display("FAIL squash_once got %b want 0", squash_ir); end
        vectors++; if (pc_out !== 9'h001) begin miscompares++; $display("FAIL wrap_next got %h want 001", pc_out); end
        cycle(0, 0, 2'd0, 0, 1, 0, 0, 0, 8'd0, 12'd0);
        vectors++; if (squash_ir !== 1'b0) begin miscompares++; $display("FAIL noinc_skip got %b want 0", squash_ir); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        do_goto(12'h0AB);
        cycle(0, 0, 2'd0, 0, 0, 1, 1, 0, 8'd0, 12'd0);
        vectors++; if (stack_top !== 9'h000) begin miscompares++; $display("FAIL push_top got %h want 000", stack_top); end
        cycle(0, 1, 2'd1, 1, 0, 0, 1, 1, 8'h80, 12'd0);
        vectors++; if (pc_out !== 9'h080) begin miscompares++; $display("FAIL load_wins got %h want 080", pc_out); end
        vectors++; if (stack_top !== 9'h000) begin miscompares++; $display("FAIL sp_unchanged got %h want 000", stack_top); end
        vectors++; if ({stack_overflow, stack_underflow} !== 2'b00) begin
            miscompares++; $display("FAIL cancel_flags got %b want 00", {stack_overflow, stack_underflow}); end
        cycle(0, 0, 2'd0, 0, 0, 0, 0, 1, 8'd0, 12'd0);
        vectors++; if (stack_top !== 9'h0AB) begin miscompares++; $display("FAIL pop_after got %h want 0AB", stack_top); end
        // reset lands on the first CALL cycle; the second cycle acts on reset state
        do_goto(12'h033);
        cycle(1, 1, 2'd1, 0, 0, 1, 0, 0, 8'h55, 12'd0);
        cycle(0, 0, 2'd0, 0, 0, 0, 1, 0, 8'd0, 12'd0);
        vectors++; if (pc_out !== 9'h000) begin miscompares++; $display("FAIL rst_mid_pc got %h want 000", pc_out); end
        cycle(0, 0, 2'd0, 0, 0, 0, 0, 1, 8'd0, 12'd0);
        vectors++; if (stack_top !== 9'h000) begin miscompares++; $display("FAIL rst_mid_stack got %h want 000", stack_top); end
        vectors++; if (stack_underflow !== 1'b0) begin miscompares++; $display("FAIL rst_mid_unf got %b want 0", stack_underflow); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(63) == 0), ($urandom_range(3) == 0), 2'($urandom_range(3)),
                  ($urandom_range(1) == 0), ($urandom_range(2) == 0), ($urandom_range(3) == 0),
                  ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                  8'($urandom), 12'($urandom));
            vectors++; if (pc_out !== 9'(m_pc)) begin miscompares++; $display("FAIL rnd_pc got %h want %h", pc_out, 9'(m_pc)); end
            vectors++; if (stack_top !== 9'(m_stk[m_sp])) begin
                miscompares++; $display("FAIL rnd_top got %h want %h", stack_top, 9'(m_stk[m_sp])); end
            vectors++; if ({squash_ir, stack_overflow, stack_underflow} !== {m_sq, m_ovf, m_unf}) begin
                miscompares++; $display("FAIL rnd_flags got %b want %b",
                                        {squash_ir, stack_overflow, stack_underflow}, {m_sq, m_ovf, m_unf}); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_goto_wrap();
        test_same_cycle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
